// File: rtl/stlc_pkg.sv
// Shared types and constants for the two-road phase scheduler:
// lamp encodings, phase codes and timing-register addresses.
package stlc_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [2:0] {
    PH_INIT = 3'd0,
    PH_G1   = 3'd1,
    PH_Y1   = 3'd2,
    PH_AR1  = 3'd3,
    PH_G2   = 3'd4,
    PH_Y2   = 3'd5,
    PH_AR2  = 3'd6
  } phase_t;

  localparam logic [1:0] CFG_MIN_GREEN = 2'd0;
  localparam logic [1:0] CFG_MAX_GREEN = 2'd1;
  localparam logic [1:0] CFG_YELLOW    = 2'd2;
  localparam logic [1:0] CFG_ALL_RED   = 2'd3;

  // Returns {light1, light2} for a phase; anything not green/yellow shows red.
  function automatic logic [5:0] lamps_of(input phase_t ph);
    case (ph)
      PH_G1:   return {LAMP_GRN, LAMP_RED};
      PH_Y1:   return {LAMP_YEL, LAMP_RED};
      PH_G2:   return {LAMP_RED, LAMP_GRN};
      PH_Y2:   return {LAMP_RED, LAMP_YEL};
      default: return {LAMP_RED, LAMP_RED};
    endcase
  endfunction

endpackage

// File: rtl/stlc_cfg_regs.sv
// Software-programmable phase timing registers. A written zero is stored
// as one so every phase lasts at least a cycle; reset beats a same-cycle write.
module stlc_cfg_regs
  import stlc_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int MIN_GREEN_RST = 4,
  parameter int MAX_GREEN_RST = 16,
  parameter int YELLOW_RST    = 2,
  parameter int ALL_RED_RST   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [CNT_W-1:0] min_green,
  output logic [CNT_W-1:0] max_green,
  output logic [CNT_W-1:0] yellow,
  output logic [CNT_W-1:0] all_red
);

  logic [CNT_W-1:0] wr_val;

  assign wr_val = (cfg_data == '0) ? CNT_W'(1) : cfg_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_green <= CNT_W'(MIN_GREEN_RST);
      max_green <= CNT_W'(MAX_GREEN_RST);
      yellow    <= CNT_W'(YELLOW_RST);
      all_red   <= CNT_W'(ALL_RED_RST);
    end else if (cfg_we) begin
      case (cfg_addr)
        CFG_MIN_GREEN: min_green <= wr_val;
        CFG_MAX_GREEN: max_green <= wr_val;
        CFG_YELLOW:    yellow    <= wr_val;
        CFG_ALL_RED:   all_red   <= wr_val;
        default:       ;
      endcase
    end
  end

endmodule

// File: rtl/stlc_phase_sched.sv
// Timed green/yellow/all-red scheduler for a two-road intersection with
// latched sensor requests and programmable phase lengths.
module stlc_phase_sched
  import stlc_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int MIN_GREEN_RST = 4,
  parameter int MAX_GREEN_RST = 16,
  parameter int YELLOW_RST    = 2,
  parameter int ALL_RED_RST   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S1,
  input  logic             S2,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [2:0]       light1,
  output logic [2:0]       light2,
  output logic [2:0]       phase,
  output logic [1:0]       req_pend
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] min_green, max_green, yellow, all_red;
  logic [CNT_W-1:0] min_m1, max_m1, yel_m1, ar_m1;
  logic [CNT_W-1:0] tmr;
  phase_t           state, state_nxt;
  logic             req1, req2, req1_nxt, req2_nxt;

  stlc_cfg_regs #(
    .CNT_W         (CNT_W),
    .MIN_GREEN_RST (MIN_GREEN_RST),
    .MAX_GREEN_RST (MAX_GREEN_RST),
    .YELLOW_RST    (YELLOW_RST),
    .ALL_RED_RST   (ALL_RED_RST)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .min_green (min_green),
    .max_green (max_green),
    .yellow    (yellow),
    .all_red   (all_red)
  );

  // Registers never hold zero, so these cannot underflow.
  assign min_m1 = min_green - ONE;
  assign max_m1 = max_green - ONE;
  assign yel_m1 = yellow - ONE;
  assign ar_m1  = all_red - ONE;

  always_comb begin
    state_nxt = state;
    case (state)
      PH_INIT: if (tmr == ar_m1) state_nxt = PH_G1;
      PH_G1:   if (tmr >= min_m1 && req2 && (!S1 || tmr >= max_m1)) state_nxt = PH_Y1;
      PH_Y1:   if (tmr == yel_m1) state_nxt = PH_AR1;
      PH_AR1:  if (tmr == ar_m1) state_nxt = PH_G2;
      PH_G2:   if (tmr >= min_m1 && req1 && (!S2 || tmr >= max_m1)) state_nxt = PH_Y2;
      PH_Y2:   if (tmr == yel_m1) state_nxt = PH_AR2;
      PH_AR2:  if (tmr == ar_m1) state_nxt = PH_G1;
      default: state_nxt = PH_INIT;
    endcase
  end

  // Entering a road's green serves its request; that clear beats a new set.
  always_comb begin
    req1_nxt = req1 | (S1 && state != PH_G1);
    req2_nxt = req2 | (S2 && state != PH_G2);
    if (state_nxt == PH_G1 && state != PH_G1) req1_nxt = 1'b0;
    if (state_nxt == PH_G2 && state != PH_G2) req2_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= PH_INIT;
      tmr    <= '0;
      req1   <= 1'b0;
      req2   <= 1'b0;
      light1 <= LAMP_RED;
      light2 <= LAMP_RED;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) tmr <= '0;
      else if (tmr != '1)     tmr <= tmr + ONE;
      req1 <= req1_nxt;
      req2 <= req2_nxt;
      {light1, light2} <= lamps_of(state_nxt);
    end
  end

  assign phase    = state;
  assign req_pend = {req2, req1};

endmodule

// File: tb/tb_stlc_phase_sched.sv
// Scenario bench for stlc_phase_sched: expected per-cycle phase/lamp vectors
// are queued from phase durations and compared as the DUT advances.
module tb_stlc_phase_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       s1, s2;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [2:0] light1, light2, phase;
  logic [1:0] req_pend;

  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stlc_phase_sched dut (
    .clk      (clk),
    .rst      (rst),
    .S1       (s1),
    .S2       (s2),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .light1   (light1),
    .light2   (light2),
    .phase    (phase),
    .req_pend (req_pend)
  );

  // {phase, light1, light2} expected for a given phase code
  function automatic logic [8:0] vec(input logic [2:0] ph);
    case (ph)
      3'd1:    return {ph, 3'b001, 3'b100};
      3'd2:    return {ph, 3'b010, 3'b100};
      3'd4:    return {ph, 3'b100, 3'b001};
      3'd5:    return {ph, 3'b100, 3'b010};
      default: return {ph, 3'b100, 3'b100};
    endcase
  endfunction

  task automatic push_run(input logic [2:0] ph, input int cnt);
    repeat (cnt) exp_q.push_back(vec(ph));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    int n;
    n = 0;
    push_run(3'd0, 2); push_run(3'd1, 1);
    while (exp_q.size() > 0) begin
      rst = (n < 2);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({phase, light1, light2} !== e) begin
        errors++;
        $display("FAIL reset step %0d: got %b expected %b", n, {phase, light1, light2}, e);
      end
      if (n >= 1) begin
        checks++;
        if (req_pend !== 2'b00) begin
          errors++;
          $display("FAIL reset_req step %0d: got %b expected 00", n, req_pend);
        end
      end
      n++;
    end
  endtask

  task automatic test_single_req();
    logic [8:0] e;
    int n;
    n = 0;
    push_run(3'd1, 3); push_run(3'd2, 2); push_run(3'd3, 1); push_run(3'd4, 1);
    while (exp_q.size() > 0) begin
      s2 = (n == 0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({phase, light1, light2} !== e) begin
        errors++;
        $display("FAIL single_req step %0d: got %b expected %b", n, {phase, light1, light2}, e);
      end
      if (n == 0 || n == 6) begin
        checks++;
        if (req_pend !== ((n == 0) ? 2'b10 : 2'b00)) begin
          errors++;
          $display("FAIL single_req_pend step %0d: got %b", n, req_pend);
        end
      end
      n++;
    end
    s2 = 1'b0;
  endtask

  // S1 held through AR2->G1: the entry clear must win, and S1 in G1 must not set req1
  task automatic test_simultaneous();
    logic [8:0] e;
    int n;
    n = 0;
    push_run(3'd4, 3); push_run(3'd5, 2); push_run(3'd6, 1); push_run(3'd1, 2);
    while (exp_q.size() > 0) begin
      s1 = 1'b1;
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({phase, light1, light2} !== e) begin
        errors++;
        $display("FAIL simultaneous step %0d: got %b expected %b", n, {phase, light1, light2}, e);
      end
      if (n == 0 || n >= 6) begin
        checks++;
        if (req_pend !== ((n == 0) ? 2'b01 : 2'b00)) begin
          errors++;
          $display("FAIL simultaneous_req step %0d: got %b", n, req_pend);
        end
      end
      n++;
    end
  endtask

  // Entered at G1 tmr=1 with S1 held: green runs to max_green (16 cycles total)
  task automatic test_max_green();
    logic [8:0] e;
    int n;
    n = 0;
    push_run(3'd1, 14); push_run(3'd2, 2); push_run(3'd3, 1); push_run(3'd4, 1);
    while (exp_q.size() > 0) begin
      s1 = 1'b1;
      s2 = (n == 0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({phase, light1, light2} !== e) begin
        errors++;
        $display("FAIL max_green step %0d: got %b expected %b", n, {phase, light1, light2}, e);
      end
      n++;
    end
    s2 = 1'b0;
    checks++;
    if (req_pend !== 2'b01) begin
      errors++;
      $display("FAIL max_green_req: got %b expected 01", req_pend);
    end
  endtask

  task automatic test_s1_drop();
    logic [8:0] e;
    int n;
    n = 0;
    push_run(3'd4, 3); push_run(3'd5, 2); push_run(3'd6, 1); push_run(3'd1, 1);
    push_run(3'd1, 7); push_run(3'd2, 2); push_run(3'd3, 1); push_run(3'd4, 1);
    while (exp_q.size() > 0) begin
      s1 = (n < 14);
      s2 = (n == 7);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({phase, light1, light2} !== e) begin
        errors++;
        $display("FAIL s1_drop step %0d: got %b expected %b", n, {phase, light1, light2}, e);
      end
      n++;
    end
    s1 = 1'b0;
    s2 = 1'b0;
    checks++;
    if (req_pend !== 2'b00) begin
      errors++;
      $display("FAIL s1_drop_req: got %b expected 00", req_pend);
    end
  endtask

  // Long idle green; min_green=200 makes a wrapped timer hold G1 past the request
  task automatic test_no_demand();
    logic [8:0] e;
    int n;
    n = 0;
    push_run(3'd4, 3); push_run(3'd5, 2); push_run(3'd6, 1); push_run(3'd1, 1);
    push_run(3'd1, 294); push_run(3'd2, 2); push_run(3'd3, 1); push_run(3'd4, 1);
    while (exp_q.size() > 0) begin
      s1 = (n == 0);
      s2 = (n == 300);
      cfg_we = (n == 10);
      cfg_addr = 2'd0;
      cfg_data = 8'd200;
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({phase, light1, light2} !== e) begin
        errors++;
        $display("FAIL no_demand step %0d: got %b expected %b", n, {phase, light1, light2}, e);
      end
      n++;
    end
    s1 = 1'b0;
    s2 = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic test_cfg_write();
    logic [8:0] e;
    int n;
    n = 0;
    push_run(3'd4, 3); push_run(3'd5, 1); push_run(3'd6, 3); push_run(3'd1, 1);
    push_run(3'd1, 3); push_run(3'd2, 1); push_run(3'd3, 3); push_run(3'd4, 1);
    while (exp_q.size() > 0) begin
      s1 = (n == 0);
      s2 = (n == 8);
      cfg_we = (n <= 2);
      case (n)
        0:       begin cfg_addr = 2'd0; cfg_data = 8'd4; end
        1:       begin cfg_addr = 2'd2; cfg_data = 8'd0; end
        2:       begin cfg_addr = 2'd3; cfg_data = 8'd3; end
        default: ;
      endcase
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({phase, light1, light2} !== e) begin
        errors++;
        $display("FAIL cfg_write step %0d: got %b expected %b", n, {phase, light1, light2}, e);
      end
      n++;
    end
    s1 = 1'b0;
    s2 = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic test_min_green_mid();
    logic [8:0] e;
    int n;
    n = 0;
    push_run(3'd4, 3); push_run(3'd5, 1); push_run(3'd6, 3); push_run(3'd1, 1);
    push_run(3'd1, 9); push_run(3'd2, 1); push_run(3'd3, 3); push_run(3'd4, 1);
    while (exp_q.size() > 0) begin
      s1 = (n == 0);
      s2 = (n == 13);
      cfg_we = (n == 13);
      cfg_addr = 2'd0;
      cfg_data = 8'd10;
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({phase, light1, light2} !== e) begin
        errors++;
        $display("FAIL min_green_mid step %0d: got %b expected %b", n, {phase, light1, light2}, e);
      end
      n++;
    end
    s1 = 1'b0;
    s2 = 1'b0;
    cfg_we = 1'b0;
  endtask

  // Reset in Y2 with a config write and a sensor active; defaults must govern afterwards
  task automatic test_reset_mid();
    logic [8:0] e;
    int n;
    n = 0;
    push_run(3'd4, 9); push_run(3'd5, 1); push_run(3'd0, 1); push_run(3'd1, 1);
    push_run(3'd1, 3); push_run(3'd2, 2); push_run(3'd3, 1); push_run(3'd4, 1);
    while (exp_q.size() > 0) begin
      s1 = (n == 0);
      s2 = (n == 10 || n == 12);
      rst = (n == 10);
      cfg_we = (n == 10);
      cfg_addr = 2'd3;
      cfg_data = 8'd5;
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({phase, light1, light2} !== e) begin
        errors++;
        $display("FAIL reset_mid step %0d: got %b expected %b", n, {phase, light1, light2}, e);
      end
      if (n == 9 || n == 10) begin
        checks++;
        if (req_pend !== ((n == 9) ? 2'b01 : 2'b00)) begin
          errors++;
          $display("FAIL reset_mid_req step %0d: got %b", n, req_pend);
        end
      end
      n++;
    end
    s1 = 1'b0;
    s2 = 1'b0;
    rst = 1'b0;
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s1 = 1'b0;
    s2 = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = 2'd0;
    cfg_data = 8'd0;
    test_reset();
    test_single_req();
    test_simultaneous();
    test_max_green();
    test_s1_drop();
    test_no_demand();
    test_cfg_write();
    test_min_green_mid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stlc_phase_sched.md
Name: stlc_phase_sched

Overview:
- Timed phase scheduler for the two-road traffic-light intersection.
- Sequences green/yellow/all-red phases using per-phase cycle counts held in registers that software can program.
- Latches vehicle-sensor requests and grants green to a waiting road only after the current road has served its minimum green.
- Replaces the fixed-step sequencer. Drives the same light1/light2 encoding: 3'b100 red, 3'b010 yellow, 3'b001 green.

Parameters:
- CNT_W, 8: width of the phase timer and of each timing register.
- MIN_GREEN_RST, 4: reset value of min_green, in cycles.
- MAX_GREEN_RST, 16: reset value of max_green, in cycles.
- YELLOW_RST, 2: reset value of yellow, in cycles.
- ALL_RED_RST, 1: reset value of all_red, in cycles.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- S1  in  1  vehicle waiting on road 1 (level).
- S2  in  1  vehicle waiting on road 2 (level).
- cfg_we  in  1  write strobe for the timing registers.
- cfg_addr  in  2  register select: 0 min_green, 1 max_green, 2 yellow, 3 all_red.
- cfg_data  in  CNT_W  write data.
- light1  out  3  road 1 lamp (one-hot).
- light2  out  3  road 2 lamp (one-hot).
- phase  out  3  current state code, for debug.
- req_pend  out  2  latched requests, {req2, req1}.

Behaviour:
- Reset (rst high at posedge):
  - state=INIT, tmr=0, req=2'b00, timing registers = *_RST values.
  - light1=light2=3'b100. A config write in the same cycle is ignored.
- State codes: INIT=0, G1=1, Y1=2, AR1=3, G2=4, Y2=5, AR2=6.
- Lamps are decoded from the state register only; no latency beyond the state flop.
  - INIT, AR1, AR2: both lamps 100.
  - G1: light1=001, light2=100.
  - Y1: light1=010, light2=100.
  - G2: light1=100, light2=001.
  - Y2: light1=100, light2=010.
- Timer:
  - tmr=0 on the first cycle of every state; increments each cycle; saturates at all-ones.
  - Any state change clears it.
- Transitions, evaluated at each posedge:
  - INIT -> G1 when tmr == all_red-1.
  - G1 -> Y1 when tmr >= min_green-1 AND req2 AND (!S1 OR tmr >= max_green-1).
  - Y1 -> AR1 when tmr == yellow-1.
  - AR1 -> G2 when tmr == all_red-1.
  - G2, Y2, AR2 mirror G1, Y1, AR1 with the roads swapped. AR2 -> G1.
  - Illegal state code -> INIT, tmr cleared.
- Green hold: with no opposing request, a green is held indefinitely regardless of max_green.
- Requests:
  - req1 sets on any cycle S1=1 while state != G1. It clears on the cycle the state enters G1; the clear wins over a simultaneous set.
  - req2 is symmetric with S2 and G2.
  - S1 while in G1 does not set req1.
- Timing registers:
  - A write takes effect on the next cycle's comparison, including in the current phase.
  - A written value of 0 is stored as 1.
  - If max_green < min_green, the effective max is min_green, because the min condition is ANDed in.
- Phase lengths in cycles: yellow and all-red phases last exactly yellow and all_red cycles. A green lasts at least min_green cycles.
- Reset mid-phase: immediate return to INIT with both lamps red on the next cycle; pending requests are lost.

Decomposition:
- Shared package stlc_pkg holds:
  - Lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001.
  - Enum phase_t with the codes above.
  - Register address constants CFG_MIN_GREEN through CFG_ALL_RED.
- One sub-module, stlc_cfg_regs:
  - Contains the four timing registers with zero-to-one coercion.
  - Write decode and reset values.
  - Contains no sequencing logic.

Test Plan:
- Reset and power-up: rst high 2 cycles, then low -> lamps 100/100 for 1 cycle (INIT), then G1 (001/100); req_pend=00.
- Single request, defaults:
  - Stimulus: S2 pulsed 1 cycle at G1 tmr=0, S1=0.
  - Required: req_pend=10 next cycle; G1 lasts exactly 4 cycles; Y1 2 cycles; AR1 1 cycle; then G2 with req2 cleared.
- Extension and max green:
  - Stimulus: S1 held 1, S2 asserted during G1.
  - Required: G1 lasts exactly 16 cycles, then Y1.
  - Repeat with S1 dropping at G1 tmr=7: Y1 entered when tmr=7.
- No demand: neither sensor ever asserts -> G1 held for 100+ cycles; timer saturates at 255 without wrapping or changing state.
- Config write:
  - Stimulus: write yellow=0 and all_red=3, then trigger the G1->G2 swap.
  - Required: Y1 lasts 1 cycle; AR1 lasts 3 cycles.
  - Also: min_green=10 written mid-G1 at tmr=5 with req2 set delays Y1 until tmr=9.
- Simultaneous events and mid-phase reset:
  - S1=1 on the cycle AR2->G1 -> req1 stays 0.
  - rst during Y2 -> next cycle INIT, lamps 100/100, req_pend=00, registers back to defaults.
